// File: rtl/memory_line_server_pkg.sv
// Shared widths, defaults and enums for the memory line server and its arbiter.
`ifndef CACHE_ADDR_WIDTH
`define CACHE_ADDR_WIDTH 32
`endif
`ifndef CACHE_LINE_WIDTH
`define CACHE_LINE_WIDTH 128
`endif
`ifndef MEM_NUM_LINES
`define MEM_NUM_LINES 1024
`endif
`ifndef MEM_LATENCY
`define MEM_LATENCY 10
`endif

package memory_line_server_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = `CACHE_ADDR_WIDTH;
    localparam int unsigned DEF_LINE_WIDTH = `CACHE_LINE_WIDTH;
    localparam int unsigned DEF_NUM_LINES  = `MEM_NUM_LINES;
    localparam int unsigned DEF_LATENCY    = `MEM_LATENCY;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESPOND
    } mem_state_t;

    typedef enum logic {
        REQ_ICACHE,
        REQ_DCACHE
    } mem_req_id_t;

endpackage

// File: rtl/memory_line_server_arbiter.sv
// Two-way round-robin arbiter; the pointer moves to the losing side after every
// granted request so that a continuously requesting port cannot starve the other.
module line_rr_arbiter
    import memory_line_server_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       icacheReq_i,
    input  logic       dcacheReq_i,
    input  logic       update_i,
    output logic [1:0] grant_o
);

    mem_req_id_t ptr_q;
    mem_req_id_t ptr_d;

    always_comb begin
        grant_o = 2'b00;
        if (icacheReq_i && dcacheReq_i) begin
            grant_o = (ptr_q == REQ_ICACHE) ? 2'b01 : 2'b10;
        end else if (icacheReq_i) begin
            grant_o = 2'b01;
        end else if (dcacheReq_i) begin
            grant_o = 2'b10;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (update_i) begin
            if (grant_o[0]) begin
                ptr_d = REQ_DCACHE;
            end else if (grant_o[1]) begin
                ptr_d = REQ_ICACHE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= REQ_ICACHE;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/memory_line_server.sv
// Main-memory responder for icache/dcache line fills: one request in flight,
// fixed LATENCY from accept to a one-cycle response pulse on the granted port.
module memory_line_server
    import memory_line_server_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int unsigned NUM_LINES  = DEF_NUM_LINES,
    parameter int unsigned LATENCY    = DEF_LATENCY
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] icache_req_addr,
    input  logic                  icache_req_valid,
    output logic [LINE_WIDTH-1:0] icache_rsp_data,
    output logic                  icache_rsp_valid,
    input  logic [ADDR_WIDTH-1:0] dcache_req_addr,
    input  logic                  dcache_req_valid,
    input  logic                  dcache_req_is_write,
    input  logic [LINE_WIDTH-1:0] dcache_req_wdata,
    output logic [LINE_WIDTH-1:0] dcache_rsp_data,
    output logic                  dcache_rsp_valid
);

    localparam int unsigned OFFSET_BITS = $clog2(LINE_WIDTH / 8);
    localparam int unsigned INDEX_BITS  = $clog2(NUM_LINES);
    localparam int unsigned COUNT_BITS  = $clog2(LATENCY + 1);
    localparam logic [COUNT_BITS-1:0] COUNT_LOAD = COUNT_BITS'(LATENCY - 1);
    localparam logic [COUNT_BITS-1:0] COUNT_ONE  = COUNT_BITS'(1);

    if (LATENCY < 2) begin : gLatencyCheck
        $error("memory_line_server: LATENCY must be 2 or more");
    end

    logic [LINE_WIDTH-1:0] mem [NUM_LINES];

    mem_state_t            state_q,   state_d;
    logic [COUNT_BITS-1:0] count_q,   count_d;
    mem_req_id_t           grantId_q, grantId_d;
    logic [INDEX_BITS-1:0] lineIdx_q, lineIdx_d;
    logic                  isWrite_q, isWrite_d;
    logic [LINE_WIDTH-1:0] wdata_q,   wdata_d;
    logic [LINE_WIDTH-1:0] rspData_q, rspData_d;

    logic       accept;
    logic [1:0] grant;
    logic       unusedAddrBits;

    // Offset and upper address bits are deliberately dropped so addresses alias.
    assign unusedAddrBits = ^{icache_req_addr, dcache_req_addr};

    assign accept = (state_q == IDLE) && (icache_req_valid || dcache_req_valid);

    line_rr_arbiter uArbiter (
        .clock       (clock),
        .reset       (reset),
        .icacheReq_i (icache_req_valid),
        .dcacheReq_i (dcache_req_valid),
        .update_i    (accept),
        .grant_o     (grant)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        grantId_d = grantId_q;
        lineIdx_d = lineIdx_q;
        isWrite_d = isWrite_q;
        wdata_d   = wdata_q;
        rspData_d = rspData_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    count_d = COUNT_LOAD;
                    if (grant[1]) begin
                        grantId_d = REQ_DCACHE;
                        lineIdx_d = dcache_req_addr[OFFSET_BITS +: INDEX_BITS];
                        isWrite_d = dcache_req_is_write;
                        wdata_d   = dcache_req_wdata;
                    end else begin
                        grantId_d = REQ_ICACHE;
                        lineIdx_d = icache_req_addr[OFFSET_BITS +: INDEX_BITS];
                        isWrite_d = 1'b0;
                    end
                end
            end
            BUSY: begin
                count_d = count_q - COUNT_ONE;
                // The response line is captured on the last BUSY cycle so RESPOND drives a flop.
                if (count_q == COUNT_ONE) begin
                    state_d   = RESPOND;
                    rspData_d = isWrite_q ? wdata_q : mem[lineIdx_q];
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            grantId_q <= REQ_ICACHE;
            lineIdx_q <= '0;
            isWrite_q <= 1'b0;
            wdata_q   <= '0;
            rspData_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            grantId_q <= grantId_d;
            lineIdx_q <= lineIdx_d;
            isWrite_q <= isWrite_d;
            wdata_q   <= wdata_d;
            rspData_q <= rspData_d;
        end
    end

    // A reset forces state_q out of RESPOND, so an interrupted write never lands.
    always_ff @(posedge clock) begin
        if ((state_q == RESPOND) && isWrite_q) begin
            mem[lineIdx_q] <= wdata_q;
        end
    end

    assign icache_rsp_valid = (state_q == RESPOND) && (grantId_q == REQ_ICACHE);
    assign dcache_rsp_valid = (state_q == RESPOND) && (grantId_q == REQ_DCACHE);
    assign icache_rsp_data  = icache_rsp_valid ? rspData_q : '0;
    assign dcache_rsp_data  = dcache_rsp_valid ? rspData_q : '0;

endmodule

// File: tb/tb_memory_line_server.sv
// Randomized and directed bench for memory_line_server against a transaction-level
// model: server is free or busy until a response cycle, with a reference line array.
`timescale 1ns/1ps
module tb_memory_line_server;

    localparam int LAT  = 10;
    localparam int LAT2 = 2;
    localparam logic [127:0] LINE_A = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    localparam logic [127:0] LINE_B = 128'h0BAD_F00D_1111_2222_3333_4444_5555_6666;
    localparam logic [127:0] LINE_C = 128'hC0C0_C0C0_1234_5678_9ABC_DEF0_0F0F_0F0F;
    localparam logic [127:0] LINE_D = 128'hDDDD_DDDD_EEEE_EEEE_FFFF_FFFF_0000_0001;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [31:0]  icacheReqAddr = '0;
    logic         icacheReqValid = 1'b0;
    logic [127:0] icacheRspData;
    logic         icacheRspValid;
    logic [31:0]  dcacheReqAddr = '0;
    logic         dcacheReqValid = 1'b0;
    logic         dcacheReqIsWrite = 1'b0;
    logic [127:0] dcacheReqWdata = '0;
    logic [127:0] dcacheRspData;
    logic         dcacheRspValid;

    logic [31:0]  icacheReqAddr2 = '0;
    logic         icacheReqValid2 = 1'b0;
    logic [127:0] icacheRspData2;
    logic         icacheRspValid2;
    logic [31:0]  dcacheReqAddr2 = '0;
    logic         dcacheReqValid2 = 1'b0;
    logic         dcacheReqIsWrite2 = 1'b0;
    logic [127:0] dcacheReqWdata2 = '0;
    logic [127:0] dcacheRspData2;
    logic         dcacheRspValid2;

    memory_line_server #(.LATENCY(LAT)) dut (
        .clock               (clock),
        .reset               (reset),
        .icache_req_addr     (icacheReqAddr),
        .icache_req_valid    (icacheReqValid),
        .icache_rsp_data     (icacheRspData),
        .icache_rsp_valid    (icacheRspValid),
        .dcache_req_addr     (dcacheReqAddr),
        .dcache_req_valid    (dcacheReqValid),
        .dcache_req_is_write (dcacheReqIsWrite),
        .dcache_req_wdata    (dcacheReqWdata),
        .dcache_rsp_data     (dcacheRspData),
        .dcache_rsp_valid    (dcacheRspValid)
    );

    memory_line_server #(.LATENCY(LAT2), .NUM_LINES(16)) dut2 (
        .clock               (clock),
        .reset               (reset),
        .icache_req_addr     (icacheReqAddr2),
        .icache_req_valid    (icacheReqValid2),
        .icache_rsp_data     (icacheRspData2),
        .icache_rsp_valid    (icacheRspValid2),
        .dcache_req_addr     (dcacheReqAddr2),
        .dcache_req_valid    (dcacheReqValid2),
        .dcache_req_is_write (dcacheReqIsWrite2),
        .dcache_req_wdata    (dcacheReqWdata2),
        .dcache_rsp_data     (dcacheRspData2),
        .dcache_rsp_valid    (dcacheRspValid2)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: one transaction at a time, response exactly LAT cycles after accept.
    logic [127:0] refMem [int];
    bit           pending = 0;
    int           expCycle, expPort, expIdx;
    logic         expWrite;
    logic [127:0] expWdata;
    int           rrPtr = 0;
    bit           iDone = 0, dDone = 0;
    int           iAcceptCycle, dAcceptCycle, iRespCycle, dRespCycle;
    logic [127:0] iRespData, dRespData;
    int           dPulses = 0;

    function automatic int lineIndex(input logic [31:0] a);
        return int'((a / 16) % 1024);
    endfunction

    always @(negedge clock) begin : monitor
        logic         expIV, expDV;
        logic [127:0] expI, expD, expLine;
        bit           chkI, chkD, known, respNow;
        if (dcacheRspValid) dPulses++;
        if (reset) begin
            checkOutput("reset_icache_valid", 128'(icacheRspValid), 128'(0));
            checkOutput("reset_dcache_valid", 128'(dcacheRspValid), 128'(0));
            checkOutput("reset_icache_data", icacheRspData, '0);
            checkOutput("reset_dcache_data", dcacheRspData, '0);
            pending = 0;
            rrPtr = 0;
        end else begin
            expIV = 1'b0; expDV = 1'b0; expI = '0; expD = '0; expLine = '0;
            chkI = 1; chkD = 1; known = 1; respNow = 0;
            if (pending && cyc == expCycle) begin
                respNow = 1;
                pending = 0;
                if (expWrite) begin
                    refMem[expIdx] = expWdata;
                    expLine = expWdata;
                end else if (refMem.exists(expIdx)) begin
                    expLine = refMem[expIdx];
                end else begin
                    known = 0;
                end
                if (expPort == 0) begin
                    expIV = 1'b1; expI = expLine; chkI = known;
                end else begin
                    expDV = 1'b1; expD = expLine; chkD = known;
                end
            end
            checkOutput("icache_rsp_valid", 128'(icacheRspValid), 128'(expIV));
            checkOutput("dcache_rsp_valid", 128'(dcacheRspValid), 128'(expDV));
            if (chkI) checkOutput("icache_rsp_data", icacheRspData, expI);
            if (chkD) checkOutput("dcache_rsp_data", dcacheRspData, expD);
            if (respNow) begin
                if (expPort == 0) begin
                    iDone = 1; iRespCycle = cyc; iRespData = icacheRspData;
                end else begin
                    dDone = 1; dRespCycle = cyc; dRespData = dcacheRspData;
                end
            end
            if (!pending && !respNow && (icacheReqValid || dcacheReqValid)) begin
                if (icacheReqValid && dcacheReqValid) expPort = rrPtr;
                else expPort = icacheReqValid ? 0 : 1;
                rrPtr = 1 - expPort;
                pending = 1;
                expCycle = cyc + LAT;
                if (expPort == 0) begin
                    expIdx = lineIndex(icacheReqAddr);
                    expWrite = 1'b0;
                    iAcceptCycle = cyc;
                end else begin
                    expIdx = lineIndex(dcacheReqAddr);
                    expWrite = dcacheReqIsWrite;
                    expWdata = dcacheReqWdata;
                    dAcceptCycle = cyc;
                end
            end
        end
    end

    task automatic icacheRead(input logic [31:0] addr, output int acc, output int rsp,
                              output logic [127:0] data);
        int waited = 0;
        icacheReqAddr = addr;
        icacheReqValid = 1'b1;
        iDone = 0;
        while (!iDone && waited < 60) begin
            @(posedge clock); #1;
            waited++;
        end
        if (!iDone) checkOutput("icache_timeout", 128'(0), 128'(1));
        icacheReqValid = 1'b0;
        acc = iAcceptCycle; rsp = iRespCycle; data = iRespData;
    endtask

    task automatic dcacheAccess(input logic [31:0] addr, input logic wr, input logic [127:0] wdata,
                                input bit toggle, output int acc, output int rsp,
                                output logic [127:0] data);
        int waited = 0;
        dcacheReqAddr = addr;
        dcacheReqIsWrite = wr;
        dcacheReqWdata = wdata;
        dcacheReqValid = 1'b1;
        dDone = 0;
        while (!dDone && waited < 60) begin
            @(posedge clock); #1;
            waited++;
            if (toggle) begin
                dcacheReqWdata = {$urandom, $urandom, $urandom, $urandom};
                dcacheReqIsWrite = ~dcacheReqIsWrite;
            end
        end
        if (!dDone) checkOutput("dcache_timeout", 128'(0), 128'(1));
        dcacheReqValid = 1'b0;
        dcacheReqIsWrite = 1'b0;
        dcacheReqWdata = '0;
        acc = dAcceptCycle; rsp = dRespCycle; data = dRespData;
    endtask

    task automatic applyStimulus(input int cycles);
        int endCyc = cyc + cycles;
        fork
            begin
                int a, r;
                logic [127:0] d;
                while (cyc < endCyc) begin
                    icacheRead(($urandom_range(0, 3) << 14) | ($urandom_range(0, 7) << 4) |
                               $urandom_range(0, 15), a, r, d);
                    repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
                end
            end
            begin
                int a, r;
                logic [127:0] d;
                while (cyc < endCyc) begin
                    dcacheAccess(($urandom_range(0, 3) << 14) | ($urandom_range(0, 7) << 4) |
                                 $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                                 {$urandom, $urandom, $urandom, $urandom}, 1'b0, a, r, d);
                    repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
                end
            end
        join
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : mainSeq
        int start, acc, rsp, acc2, rsp2, pulsesBefore, k, prev, waited, pulseCyc;
        logic [127:0] data, data2;
        logic [127:0] lines2 [4];
        bit seen;

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Write then read through the other port.
        start = cyc;
        dcacheAccess(32'h0000_0040, 1'b1, LINE_A, 1'b0, acc, rsp, data);
        checkOutput("wr_ack_latency", 128'(rsp - start), 128'(LAT));
        checkOutput("wr_echo", data, LINE_A);
        pulsesBefore = dPulses;
        icacheRead(32'h0000_0040, acc, rsp, data);
        checkOutput("rd_accept_cycle", 128'(acc - start), 128'(LAT + 1));
        checkOutput("rd_resp_cycle", 128'(rsp - start), 128'(2 * LAT + 1));
        checkOutput("rd_data", data, LINE_A);
        checkOutput("rd_no_dcache_pulse", 128'(dPulses - pulsesBefore), 128'(0));

        // Offset bits and upper bits alias to the same line.
        dcacheAccess(32'h0000_004C, 1'b0, '0, 1'b0, acc, rsp, data);
        checkOutput("offset_alias", data, LINE_A);
        dcacheAccess(32'h0000_4040, 1'b0, '0, 1'b0, acc, rsp, data);
        checkOutput("upper_alias", data, LINE_A);

        // Simultaneous requests straight after reset: icache first, then pointer returns.
        reset = 1'b1;
        repeat (2) begin @(posedge clock); #1; end
        reset = 1'b0;
        for (int pair = 0; pair < 2; pair++) begin
            start = cyc;
            fork
                icacheRead(32'h0000_0080, acc, rsp, data);
                dcacheAccess(32'h0000_00C0, 1'b0, '0, 1'b0, acc2, rsp2, data2);
            join
            checkOutput("pair_icache_resp", 128'(rsp - start), 128'(LAT));
            checkOutput("pair_dcache_accept", 128'(acc2 - start), 128'(LAT + 1));
            checkOutput("pair_dcache_resp", 128'(rsp2 - start), 128'(2 * LAT + 1));
        end

        // Inputs changed during BUSY are ignored; a late icache request waits.
        start = cyc;
        fork
            dcacheAccess(32'h0000_0200, 1'b1, LINE_B, 1'b1, acc2, rsp2, data2);
            begin
                repeat (3) begin @(posedge clock); #1; end
                icacheRead(32'h0000_0200, acc, rsp, data);
            end
        join
        checkOutput("busy_write_echo", data2, LINE_B);
        checkOutput("busy_icache_accept", 128'(acc - start), 128'(LAT + 1));
        checkOutput("busy_stored_line", data, LINE_B);

        // Reset in the middle of a write drops it.
        dcacheAccess(32'h0000_0100, 1'b1, LINE_C, 1'b0, acc, rsp, data);
        pulsesBefore = dPulses;
        dcacheReqAddr = 32'h0000_0100;
        dcacheReqIsWrite = 1'b1;
        dcacheReqWdata = LINE_D;
        dcacheReqValid = 1'b1;
        repeat (5) begin @(posedge clock); #1; end
        reset = 1'b1;
        dcacheReqValid = 1'b0;
        dcacheReqIsWrite = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (12) begin @(posedge clock); #1; end
        checkOutput("dropped_no_pulse", 128'(dPulses - pulsesBefore), 128'(0));
        dcacheAccess(32'h0000_0100, 1'b0, '0, 1'b0, acc, rsp, data);
        checkOutput("dropped_keeps_old", data, LINE_C);

        // Fill the random working set, then run both requesters randomly.
        for (int i = 0; i < 8; i++) begin
            dcacheAccess(i * 16, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, acc, rsp, data);
        end
        applyStimulus(600);

        // LATENCY=2 instance: writes, then a held icache stream.
        for (int i = 0; i < 4; i++) begin
            lines2[i] = {$urandom, $urandom, $urandom, $urandom};
            dcacheReqAddr2 = i * 16;
            dcacheReqIsWrite2 = 1'b1;
            dcacheReqWdata2 = lines2[i];
            dcacheReqValid2 = 1'b1;
            start = cyc;
            seen = 0;
            waited = 0;
            pulseCyc = -1;
            while (!seen && waited < 10) begin
                @(negedge clock);
                if (dcacheRspValid2) begin seen = 1; pulseCyc = cyc; end
                @(posedge clock); #1;
                waited++;
            end
            checkOutput("lat2_write_latency", 128'(pulseCyc - start), 128'(LAT2));
            dcacheReqValid2 = 1'b0;
        end
        dcacheReqIsWrite2 = 1'b0;
        icacheReqAddr2 = '0;
        icacheReqValid2 = 1'b1;
        start = cyc;
        k = 0;
        prev = 0;
        waited = 0;
        while (k < 4 && waited < 30) begin
            @(negedge clock);
            if (icacheRspValid2) begin
                checkOutput("lat2_stream_data", icacheRspData2, lines2[k]);
                if (k == 0) checkOutput("lat2_first_latency", 128'(cyc - start), 128'(LAT2));
                else checkOutput("lat2_spacing", 128'(cyc - prev), 128'(LAT2 + 1));
                prev = cyc;
                k++;
                @(posedge clock); #1;
                icacheReqAddr2 = k * 16;
            end else begin
                @(posedge clock); #1;
            end
            waited++;
        end
        if (k < 4) checkOutput("lat2_stream_timeout", 128'(k), 128'(4));
        icacheReqValid2 = 1'b0;
        repeat (3) begin @(posedge clock); #1; end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
